mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller for a simple in-order pipeline.
// ALU results are forwarded to writeback one cycle after they are accepted.
// Loads and stores issue a data-memory request and hold it until mem_ack
// arrives, or until the request has waited TIMEOUT cycles, which is fatal.
// HALTED and ERROR are terminal states; only reset leaves them.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   ex_valid, *_in    instruction fields from the EX/MEM pipeline register
//   mem_req/wr/addr/wdata   data-memory request (held stable while BUSY)
//   mem_ack, mem_rdata      data-memory response (rdata valid with ack)
//   stall             combinational; freezes upstream and the pipeline register
//   wb_valid/data/reg/en    single-cycle writeback pulse per retired op
//   halt_out, err     sticky status flags
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] wdata_in,
  input  logic [2:0]  write_r_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        halt_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_reg,
  output logic        wb_en,
  output logic        halt_out,
  output logic        err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_HALTED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_wr_q, mem_wr_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]         lat_reg_q, lat_reg_d;
  logic               lat_we_q, lat_we_d;
  logic               wb_valid_q, wb_valid_d;
  logic [15:0]        wb_data_q, wb_data_d;
  logic [2:0]         wb_reg_q, wb_reg_d;
  logic               wb_en_q, wb_en_d;
  logic               halt_q, halt_d;
  logic               err_q, err_d;
  logic               stall_c;
  logic [CNT_W-1:0]   cnt_inc;
  logic               mem_one;
  logic               mem_both;

  assign mem_one  = mem_read_in ^ mem_write_in;
  assign mem_both = mem_read_in & mem_write_in;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state, datapath capture and combinational stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_reg_d   = lat_reg_q;
    lat_we_d    = lat_we_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    wb_en_d     = wb_en_q;
    halt_d      = halt_q;
    err_d       = err_q;
    stall_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (mem_both) begin
            // Illegal encoding: fail without touching memory.
            state_d = S_ERROR;
            err_d   = 1'b1;
            stall_c = 1'b1;
          end else if (mem_one) begin
            state_d     = S_BUSY;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_wr_d    = mem_write_in;
            mem_addr_d  = alu_out_in;
            mem_wdata_d = wdata_in;
            lat_reg_d   = write_r_in;
            lat_we_d    = reg_write_in;
            stall_c     = 1'b1;
          end else if (halt_in) begin
            state_d = S_HALTED;
            halt_d  = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out_in;
            wb_reg_d   = write_r_in;
            wb_en_d    = reg_write_in;
          end
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          // Ack wins even in the cycle the wait budget runs out.
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          mem_wr_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = mem_wr_q ? mem_addr_q : mem_rdata;
          wb_reg_d   = lat_reg_q;
          wb_en_d    = mem_wr_q ? 1'b0 : lat_we_q;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            mem_req_d = 1'b0;
            mem_wr_d  = 1'b0;
          end
        end
      end

      S_HALTED: begin
      end

      S_ERROR: begin
        stall_c = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_reg_q   <= '0;
      lat_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_en_q     <= 1'b0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_reg_q   <= lat_reg_d;
      lat_we_q    <= lat_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      wb_en_q     <= wb_en_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = stall_c;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_reg    = wb_reg_q;
  assign wb_en     = wb_en_q;
  assign halt_out  = halt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized op streams.
// Expected writebacks are queued at issue/ack time; a negedge monitor pops
// and compares whenever wb_valid is seen, and checks hold values otherwise.
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] alu_out_in;
  logic [15:0] wdata_in;
  logic [2:0]  write_r_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        halt_in;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_en;
  logic        halt_out;
  logic        err;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .alu_out_in   (alu_out_in),
    .wdata_in     (wdata_in),
    .write_r_in   (write_r_in),
    .reg_write_in (reg_write_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .halt_in      (halt_in),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_en        (wb_en),
    .halt_out     (halt_out),
    .err          (err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rg;
    logic        en;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] last_data = '0;
  logic [2:0]  last_reg = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Scoreboard monitor: every wb_valid must match the oldest queued result.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'(wb_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", 64'(wb_data), 64'(mon_e.data));
          chk("wb_reg", 64'(wb_reg), 64'(mon_e.rg));
          chk("wb_en", 64'(wb_en), 64'(mon_e.en));
          last_data = mon_e.data;
          last_reg  = mon_e.rg;
        end
      end else begin
        chk("wb_hold", 64'({wb_data, wb_reg}), 64'({last_data, last_reg}));
      end
    end
  end

  task automatic clear_ex();
    ex_valid     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    halt_in      = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic apply_reset(input string name, input bit stale_ack);
    clear_ex();
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_data = '0;
    last_reg  = '0;
    @(negedge clk);
    rst = 1'b1;
    if (stale_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
    end
    #1;
    chk(name, 64'({mem_req, mem_wr, mem_addr, mem_wdata, stall, wb_valid,
                   wb_data, wb_reg, wb_en, halt_out, err}), 64'(0));
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_ex();
      alu_out_in   = 16'($urandom);
      mem_read_in  = 1'($urandom);
      mem_write_in = 1'($urandom);
      mem_ack      = 1'($urandom);
      mem_rdata    = 16'($urandom);
      #1;
      chk("idle_quiet", 64'({stall, mem_req}), 64'(0));
      @(negedge clk);
      mem_ack = 1'b0;
    end
    clear_ex();
  endtask

  task automatic do_alu(input logic [15:0] val, input logic [2:0] r, input logic we);
    clear_ex();
    ex_valid     = 1'b1;
    alu_out_in   = val;
    write_r_in   = r;
    reg_write_in = we;
    wdata_in     = 16'($urandom);
    #1;
    chk("alu_stall", 64'(stall), 64'(0));
    exp_q.push_back('{data: val, rg: r, en: we});
    @(negedge clk);
    clear_ex();
  endtask

  // ack_at: BUSY cycle (1-based) carrying mem_ack; 0 means never acked.
  task automatic do_mem(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [2:0] r, input logic we, input int ack_at,
                        input logic [15:0] rd);
    clear_ex();
    ex_valid     = 1'b1;
    mem_read_in  = ~wr;
    mem_write_in = wr;
    alu_out_in   = addr;
    wdata_in     = wd;
    write_r_in   = r;
    reg_write_in = we;
    #1;
    chk("mem_accept", 64'({stall, mem_req}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    for (int i = 1; i <= int'(TO); i++) begin
      if (i == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
        exp_q.push_back('{data: (wr ? addr : rd), rg: r, en: (wr ? 1'b0 : we)});
      end else begin
        mem_rdata = 16'($urandom);
      end
      #1;
      chk("busy_req", 64'({mem_req, mem_wr, mem_addr, mem_wdata}), 64'({1'b1, wr, addr, wd}));
      chk("busy_stall", 64'(stall), 64'(i != ack_at));
      @(negedge clk);
      mem_ack = 1'b0;
      if (i == ack_at) begin
        clear_ex();
        chk("wb_latency", 64'(wb_valid), 64'(1));
        return;
      end
    end
    clear_ex();
    #1;
    chk("timeout_err", 64'({err, stall, mem_req, wb_valid}), 64'(4'b1100));
  endtask

  task automatic do_rand_op();
    int kind;
    int ack_at;
    kind = int'($urandom_range(0, 3));
    ack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO)) : int'($urandom_range(1, 4));
    if (kind < 2)
      do_alu(16'($urandom), 3'($urandom), 1'($urandom));
    else
      do_mem(kind == 3, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
             ack_at, 16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    clear_ex();
    alu_out_in   = '0;
    wdata_in     = '0;
    write_r_in   = '0;
    reg_write_in = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    @(negedge clk);
    apply_reset("reset_state", 1'b0);

    // ALU op, load with delayed ack, store with immediate ack.
    do_alu(16'h1234, 3'd3, 1'b1);
    do_mem(1'b0, 16'h0040, 16'h0000, 3'd5, 1'b1, 3, 16'hBEEF);
    do_mem(1'b1, 16'h0010, 16'hA5A5, 3'd2, 1'b1, 1, 16'h5555);
    do_idle(3);

    // Ack in the last allowed BUSY cycle still succeeds.
    do_mem(1'b0, 16'h0100, 16'h0000, 3'd7, 1'b1, int'(TO), 16'hCAFE);
    do_alu(16'h0F0F, 3'd1, 1'b0);

    // No ack: timeout to a sticky ERROR that swallows later ops.
    do_mem(1'b0, 16'h0200, 16'h0000, 3'd4, 1'b1, 0, 16'h0000);
    ex_valid   = 1'b1;
    alu_out_in = 16'h7777;
    mem_ack    = 1'b1;
    @(negedge clk);
    clear_ex();
    mem_ack = 1'b0;
    #1;
    chk("err_sticky", 64'({err, stall, mem_req, wb_valid}), 64'(4'b1100));
    @(negedge clk);
    apply_reset("reset_after_err", 1'b0);

    // Halt: terminal, ALU and memory ops ignored, no stall.
    ex_valid = 1'b1;
    halt_in  = 1'b1;
    reg_write_in = 1'b1;
    #1;
    chk("halt_accept_stall", 64'(stall), 64'(0));
    @(negedge clk);
    clear_ex();
    chk("halt_out", 64'({halt_out, wb_valid}), 64'(2'b10));
    for (int i = 0; i < 3; i++) begin
      ex_valid     = 1'b1;
      alu_out_in   = 16'($urandom);
      mem_read_in  = (i == 2);
      reg_write_in = 1'b1;
      #1;
      chk("halted_quiet", 64'({halt_out, stall, mem_req}), 64'(3'b100));
      @(negedge clk);
    end
    clear_ex();
    apply_reset("reset_after_halt", 1'b0);

    // Both mem bits: ERROR with no request ever issued.
    ex_valid     = 1'b1;
    mem_read_in  = 1'b1;
    mem_write_in = 1'b1;
    #1;
    chk("illegal_no_req", 64'(mem_req), 64'(0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("illegal_err", 64'({err, stall, mem_req}), 64'(3'b110));
      @(negedge clk);
    end
    clear_ex();
    apply_reset("reset_after_illegal", 1'b0);

    // Reset mid-BUSY, then a stale ack that must be ignored.
    ex_valid     = 1'b1;
    mem_read_in  = 1'b1;
    alu_out_in   = 16'h0300;
    write_r_in   = 3'd6;
    reg_write_in = 1'b1;
    @(negedge clk);
    #1;
    chk("busy_before_rst", 64'({mem_req, stall}), 64'(2'b11));
    @(negedge clk);
    apply_reset("reset_mid_busy", 1'b1);
    #1;
    chk("stale_ack_ignored", 64'({wb_valid, mem_req, stall, err}), 64'(0));
    do_alu(16'h4321, 3'd0, 1'b1);

    // Randomized op stream.
    for (int n = 0; n < 60; n++) begin
      do_rand_op();
      if ($urandom_range(0, 3) == 0) do_idle(int'($urandom_range(1, 2)));
    end
    do_idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
